coin_input_sequencer: RTL
=========================

Name: coin_input_sequencer

Overview:
- Upstream stage of the vending-machine credit FSM.
- Takes three raw, bouncy, asynchronous coin-slot sensors (circle, triangle, pentagon), synchronizes and debounces them, and queues accepted coins.
- Presents coins to the credit FSM one at a time as single-cycle codes on the 2-bit coin bus: 00 none, 01 circle, 10 triangle, 11 pentagon.
- Never issues a coin while the FSM is in a drop state, which the FSM ignores.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical synchronized samples required to change a debounced level; legal range 1-15.
- FIFO_DEPTH, 4: coin queue entries; power of two, at least 2.
- GAP_CYCLES, 1: minimum idle (00) cycles after each issued coin; at least 1.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- circle_raw  input  1  raw circle sensor; asynchronous, bouncy.
- triangle_raw  input  1  raw triangle sensor.
- pentagon_raw  input  1  raw pentagon sensor.
- drop  input  1  drop output of the downstream credit FSM.
- clear_overflow  input  1  synchronous clear of the overflow flag.
- coin  output  2  registered coin code to the credit FSM.
- queued  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky flag: at least one coin was lost.

Behaviour:
- Reset:
  - reset_L=0 immediately clears all state: synchronizers, debounce counters, debounced levels, pending bits, FIFO and gap counter.
  - While reset is held: coin=00, queued=0, overflow=0.
  - A raw line held high across reset release is debounced from level 0 and therefore produces exactly one coin.
- Synchronizer: two flops per raw line. No other logic reads the raw inputs.
- Debounce, per line:
  - The counter increments each cycle that the synchronized value differs from the debounced level.
  - The counter resets to 0 on any cycle where they agree.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Edge capture, per line:
  - A debounced 0->1 transition sets that line's pending bit on the next edge.
  - If the pending bit is already set, the coin is lost and overflow is set.
  - 1->0 transitions do nothing.
- Arbiter:
  - Each cycle, moves at most one pending coin into the FIFO, in fixed priority pentagon > triangle > circle.
  - Moving a coin clears its pending bit.
  - No move occurs when the FIFO is full, unless a pop occurs the same cycle; simultaneous push and pop is legal when full.
  - A blocked coin stays pending; it is not lost.
- Issue state machine:
  - ISSUE state:
    - Pops the FIFO head when all of the following hold: FIFO non-empty, drop=0, and the current coin output is 00.
    - The popped code appears on coin for exactly one cycle, starting on the next edge.
    - The state then moves to GAP with the gap counter loaded to GAP_CYCLES.
  - GAP state:
    - coin=00; the counter decrements each cycle.
    - Returns to ISSUE when the counter reaches 0.
    - drop=1 in any state blocks a pop; the FIFO head is retained.
  - Guarantee: coin is never nonzero in a cycle where drop=1, and never nonzero in two consecutive cycles.
- Latency (empty FIFO, no pending, drop=0, ISSUE state):
  - Let edge E0 be the first clock edge sampling raw=1.
  - The coin is visible in the cycle after edge E0+DEBOUNCE_CYCLES+4, i.e. 8 edges with defaults.
  - The raw line must stay stable for this period.
- FIFO: circular buffer with wrapping read/write pointers. queued updates on the same edge as a push or pop.
- overflow:
  - Set on any lost coin.
  - Cleared by clear_overflow=1 at an edge.
  - Set has priority over clear in the same cycle.

Test Plan:
- Reset then clean pulse: reset_L low 3 cycles, release, circle_raw high 20 cycles -> exactly one cycle of coin=01 at the specified latency; queued returns to 0; overflow=0.
- Bounce rejection: triangle_raw toggles every cycle for 10 cycles, then stays high -> exactly one coin=10; no output during the toggling.
- Simultaneous coins: all three raw lines rise on the same cycle -> coin sequence 11, 00, 10, 00, 01, each coin on a single cycle separated by one idle cycle.
- Drop hold: one coin queued, drop held 1 for 5 cycles -> coin stays 00 throughout; code 01 is issued on the first legal cycle after drop falls; queued decrements at that point.
- FIFO full and overflow:
  - Setup: drop held 1; 7 spaced pentagon pulses.
  - FIFO fills (queued=4) and one coin sits pending.
  - The 6th pulse sets overflow=1; the 7th changes nothing further.
  - Release drop: exactly 5 coin=11 cycles follow.
  - clear_overflow -> overflow=0.
- Reset mid-operation: assert reset_L while 3 coins are queued and one is being issued -> coin=00 and queued=0 immediately, without waiting for a clock; after release, no coins are issued.

Source files
------------

// File: rtl/coin_input_sequencer.sv
// Coin input sequencer: synchronizes and debounces three coin-slot sensors,
// queues accepted coins and hands them to the credit FSM one per issue slot,
// never while the FSM reports drop.
module coin_input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                          clock,
  input  logic                          reset_L,
  input  logic                          circle_raw,
  input  logic                          triangle_raw,
  input  logic                          pentagon_raw,
  input  logic                          drop,
  input  logic                          clear_overflow,
  output logic [1:0]                    coin,
  output logic [$clog2(FIFO_DEPTH):0]   queued,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [3:0]       DB_LAST  = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {ST_ISSUE, ST_GAP} state_t;

  // Line index 0 = circle, 1 = triangle, 2 = pentagon; coin code = index + 1.
  logic [2:0]       raw_vec;
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0][3:0]  db_cnt_q, db_cnt_d;
  logic [2:0]       level_q, level_d;
  logic [2:0]       level_prev_q;
  logic [2:0]       pending_q, pending_d;
  logic [2:0]       rise, lost, move;
  logic             overflow_q, overflow_d;

  logic [1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [1:0]       push_code;

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [1:0]       coin_q, coin_d;

  assign raw_vec = {pentagon_raw, triangle_raw, circle_raw};

  // Debounce: a level changes only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = 4'd0;
      level_d[i]  = level_q[i];
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Issue decision, priority arbiter into the FIFO, pending/overflow bookkeeping.
  always_comb begin
    pop  = (state_q == ST_ISSUE) && (count_q != '0) && !drop && (coin_q == 2'b00);
    move = 3'b000;
    push_code = 2'b00;
    // When full, a same-cycle pop frees the slot the push writes into.
    if ((count_q != FULL_CNT) || pop) begin
      if (pending_q[2]) begin
        move = 3'b100; push_code = 2'b11;
      end else if (pending_q[1]) begin
        move = 3'b010; push_code = 2'b10;
      end else if (pending_q[0]) begin
        move = 3'b001; push_code = 2'b01;
      end
    end
    push = |move;

    rise      = level_q & ~level_prev_q;
    lost      = rise & pending_q;
    pending_d = (pending_q & ~move) | (rise & ~pending_q);

    // A lost coin in the same cycle wins over the clear request.
    if (|lost) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Issue FSM next state: one coin per pop, then GAP_CYCLES idle cycles.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    coin_d    = 2'b00;
    case (state_q)
      ST_ISSUE: begin
        if (pop) begin
          coin_d    = mem[rd_ptr_q];
          state_d   = ST_GAP;
          gap_cnt_d = GAP_W'(GAP_CYCLES);
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_ISSUE;
    endcase
  end

  // All control state, cleared immediately by reset.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      db_cnt_q     <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      pending_q    <= '0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_ISSUE;
      gap_cnt_q    <= '0;
      coin_q       <= 2'b00;
    end else begin
      sync1_q      <= raw_vec;
      sync2_q      <= sync1_q;
      db_cnt_q     <= db_cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      coin_q       <= coin_d;
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= push_code;
    end
  end

  assign coin     = coin_q;
  assign queued   = count_q;
  assign overflow = overflow_q;

endmodule
